// File: rtl/uart_mc_regif.sv
// uart_mc_regif: memory-mapped register file fronting NUM_CH UART channels.
// Address = {channel, offset}. Per-channel register map (byte offsets):
//   0x00 CTRL     b0 clk_en, b1 tx_flush, b2 rx_flush (flush bits self-clear, read 0)
//   0x04 CFG      b8:0 {tx_full_en,tx_nf_en,rx_full_en,rx_nf_en,rx_valid_en,
//                       rx_perr_en,stop_bits,parity_type,parity_en}
//   0x08 CLK_DIV
//   0x0C TX_STAT  read-only, tx FIFO count
//   0x10 RX_STAT  read-only, rx FIFO count
//   0x14 TX_DATA  write-only push
//   0x18 RX_DATA  read pops the RX FIFO head
//   0x1C RX_PEEK  read RX FIFO head without popping
//   0x20 INT_STAT b5:0 sticky event flags, write-1-to-clear
// Writing a read-only register, reading TX_DATA, an empty RX FIFO, an unknown
// offset or a channel >= NUM_CH all return SLVERR with no side effects.
// CFG and CLK_DIV may only change while both FIFOs of that channel are empty.
//
// Handshake semantics: tx_valid_o[ch] / rx_ready_o[ch] are one-cycle, one-hot
// strobes driven combinationally in the bus request cycle. A byte moves on
// every clock edge where the strobe is high; a strobe is only raised when the
// FIFO side already signals tx_ready_i[ch] / rx_valid_i[ch], so no transfer
// ever waits on the other party.
module uart_mc_regif #(
  parameter int NUM_CH = 2,
  parameter int CH_ADDR_BITS = 6,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] CLK_DIV_RST = 'h28B1,
  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ADDR_WIDTH = CH_ADDR_BITS + CH_BITS,
  localparam int NB = DATA_WIDTH / 8
) (
  input  logic                          clk_i,
  input  logic                          srst_i,
  input  logic                          mem_we_i,
  input  logic [ADDR_WIDTH-1:0]         mem_waddr_i,
  input  logic [DATA_WIDTH-1:0]         mem_wdata_i,
  input  logic [NB-1:0]                 mem_wstrb_i,
  output logic [1:0]                    mem_wresp_o,
  input  logic                          mem_re_i,
  input  logic [ADDR_WIDTH-1:0]         mem_raddr_i,
  output logic                          mem_rvalid_o,
  output logic [DATA_WIDTH-1:0]         mem_rdata_o,
  output logic [1:0]                    mem_rresp_o,
  output logic [NUM_CH-1:0]             ctrl_clk_en_o,
  output logic [NUM_CH-1:0]             tx_flush_o,
  output logic [NUM_CH-1:0]             rx_flush_o,
  output logic [NUM_CH*9-1:0]           cfg_o,
  output logic [NUM_CH*DATA_WIDTH-1:0]  clk_div_o,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   tx_count_i,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   rx_count_i,
  output logic [7:0]                    tx_data_o,
  output logic [NUM_CH-1:0]             tx_valid_o,
  input  logic [NUM_CH-1:0]             tx_ready_i,
  input  logic [NUM_CH*8-1:0]           rx_data_i,
  input  logic [NUM_CH-1:0]             rx_valid_i,
  output logic [NUM_CH-1:0]             rx_ready_o,
  input  logic [NUM_CH*6-1:0]           evt_i,
  output logic [NUM_CH-1:0]             irq_o
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [CH_ADDR_BITS-1:0] OFF_CTRL    = CH_ADDR_BITS'(32'h00);
  localparam logic [CH_ADDR_BITS-1:0] OFF_CFG     = CH_ADDR_BITS'(32'h04);
  localparam logic [CH_ADDR_BITS-1:0] OFF_CLK_DIV = CH_ADDR_BITS'(32'h08);
  localparam logic [CH_ADDR_BITS-1:0] OFF_TX_STAT = CH_ADDR_BITS'(32'h0C);
  localparam logic [CH_ADDR_BITS-1:0] OFF_RX_STAT = CH_ADDR_BITS'(32'h10);
  localparam logic [CH_ADDR_BITS-1:0] OFF_TX_DATA = CH_ADDR_BITS'(32'h14);
  localparam logic [CH_ADDR_BITS-1:0] OFF_RX_DATA = CH_ADDR_BITS'(32'h18);
  localparam logic [CH_ADDR_BITS-1:0] OFF_RX_PEEK = CH_ADDR_BITS'(32'h1C);
  localparam logic [CH_ADDR_BITS-1:0] OFF_INT     = CH_ADDR_BITS'(32'h20);

  localparam logic [CH_BITS:0] NUM_CH_V = (CH_BITS + 1)'(NUM_CH);

  // Address split
  logic [CH_BITS-1:0]      w_ch, r_ch;
  logic [CH_ADDR_BITS-1:0] w_off, r_off;
  logic                    w_ch_ok, r_ch_ok;

  assign w_ch    = mem_waddr_i[ADDR_WIDTH-1:CH_ADDR_BITS];
  assign w_off   = mem_waddr_i[CH_ADDR_BITS-1:0];
  assign r_ch    = mem_raddr_i[ADDR_WIDTH-1:CH_ADDR_BITS];
  assign r_off   = mem_raddr_i[CH_ADDR_BITS-1:0];
  assign w_ch_ok = ({1'b0, w_ch} < NUM_CH_V);
  assign r_ch_ok = ({1'b0, r_ch} < NUM_CH_V);

  // Register state
  logic [NUM_CH-1:0]     clk_en_q, tx_flush_q, rx_flush_q, irq_q;
  logic [NUM_CH-1:0]     clk_en_d, tx_flush_d, rx_flush_d;
  logic [8:0]            cfg_q [NUM_CH];
  logic [8:0]            cfg_d [NUM_CH];
  logic [DATA_WIDTH-1:0] div_q [NUM_CH];
  logic [DATA_WIDTH-1:0] div_d [NUM_CH];
  logic [5:0]            int_q [NUM_CH];
  logic [5:0]            int_d [NUM_CH];

  // Write-side decode
  logic [CNT_WIDTH-1:0] w_tx_cnt, w_rx_cnt;
  logic                 w_tx_rdy, w_idle, w_ok, w_en;
  logic [NUM_CH-1:0]    w_sel;

  // Write decode: response is combinational; only OKAY writes take effect
  always_comb begin
    w_tx_cnt = '0;
    w_rx_cnt = '0;
    w_tx_rdy = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch == CH_BITS'(c)) begin
        w_tx_cnt = tx_count_i[c*CNT_WIDTH +: CNT_WIDTH];
        w_rx_cnt = rx_count_i[c*CNT_WIDTH +: CNT_WIDTH];
        w_tx_rdy = tx_ready_i[c];
      end
    end
    w_idle = (w_tx_cnt == '0) && (w_rx_cnt == '0);
    w_ok   = 1'b0;
    if (mem_we_i && w_ch_ok) begin
      case (w_off)
        OFF_CTRL, OFF_INT:    w_ok = 1'b1;
        OFF_CFG, OFF_CLK_DIV: w_ok = w_idle;
        OFF_TX_DATA:          w_ok = mem_wstrb_i[0] && w_tx_rdy;
        default:              w_ok = 1'b0;
      endcase
    end
    w_en        = mem_we_i && w_ok;
    mem_wresp_o = (mem_we_i && !w_ok) ? RESP_SLVERR : RESP_OKAY;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel[c]      = w_en && (w_ch == CH_BITS'(c));
      tx_valid_o[c] = w_sel[c] && (w_off == OFF_TX_DATA) && !srst_i;
    end
  end

  assign tx_data_o = mem_wdata_i[7:0];

  // Next-state for per-channel registers: byte-strobed writes, flush pulses, W1C status
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      clk_en_d[c]   = clk_en_q[c];
      tx_flush_d[c] = 1'b0;
      rx_flush_d[c] = 1'b0;
      cfg_d[c]      = cfg_q[c];
      div_d[c]      = div_q[c];
      if (w_sel[c]) begin
        case (w_off)
          OFF_CTRL: begin
            if (mem_wstrb_i[0]) begin
              clk_en_d[c]   = mem_wdata_i[0];
              tx_flush_d[c] = mem_wdata_i[1];
              rx_flush_d[c] = mem_wdata_i[2];
            end
          end
          OFF_CFG: begin
            if (mem_wstrb_i[0]) cfg_d[c][7:0] = mem_wdata_i[7:0];
            if (mem_wstrb_i[1]) cfg_d[c][8]   = mem_wdata_i[8];
          end
          OFF_CLK_DIV: begin
            for (int b = 0; b < NB; b++) begin
              if (mem_wstrb_i[b]) div_d[c][8*b +: 8] = mem_wdata_i[8*b +: 8];
            end
          end
          default: ;
        endcase
      end
      // A new event on a bit being cleared keeps the bit set
      int_d[c] = (int_q[c] & ~((w_sel[c] && (w_off == OFF_INT) && mem_wstrb_i[0]) ?
                                mem_wdata_i[5:0] : 6'h00))
                 | evt_i[6*c +: 6];
    end
  end

  // Register update; irq tracks the status/mask values being written
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      clk_en_q   <= '0;
      tx_flush_q <= '0;
      rx_flush_q <= '0;
      irq_q      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cfg_q[c] <= '0;
        div_q[c] <= CLK_DIV_RST;
        int_q[c] <= '0;
      end
    end else begin
      clk_en_q   <= clk_en_d;
      tx_flush_q <= tx_flush_d;
      rx_flush_q <= rx_flush_d;
      for (int c = 0; c < NUM_CH; c++) begin
        cfg_q[c] <= cfg_d[c];
        div_q[c] <= div_d[c];
        int_q[c] <= int_d[c];
        irq_q[c] <= |(int_d[c] & cfg_d[c][8:3]);
      end
    end
  end

  // Read-side decode
  logic                 r_clk_en, r_rxv, r_ok, r_pop;
  logic [8:0]           r_cfg;
  logic [DATA_WIDTH-1:0] r_div, r_data;
  logic [CNT_WIDTH-1:0] r_txc, r_rxc;
  logic [7:0]           r_rxd;
  logic [5:0]           r_int;

  // Read mux from current (pre-write) register values
  always_comb begin
    r_clk_en = 1'b0;
    r_cfg    = '0;
    r_div    = '0;
    r_txc    = '0;
    r_rxc    = '0;
    r_rxd    = '0;
    r_rxv    = 1'b0;
    r_int    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_ch == CH_BITS'(c)) begin
        r_clk_en = clk_en_q[c];
        r_cfg    = cfg_q[c];
        r_div    = div_q[c];
        r_txc    = tx_count_i[c*CNT_WIDTH +: CNT_WIDTH];
        r_rxc    = rx_count_i[c*CNT_WIDTH +: CNT_WIDTH];
        r_rxd    = rx_data_i[8*c +: 8];
        r_rxv    = rx_valid_i[c];
        r_int    = int_q[c];
      end
    end
    r_ok   = 1'b0;
    r_pop  = 1'b0;
    r_data = '0;
    case (r_off)
      OFF_CTRL:    begin r_ok = 1'b1;  r_data = DATA_WIDTH'(r_clk_en); end
      OFF_CFG:     begin r_ok = 1'b1;  r_data = DATA_WIDTH'(r_cfg);    end
      OFF_CLK_DIV: begin r_ok = 1'b1;  r_data = r_div;                 end
      OFF_TX_STAT: begin r_ok = 1'b1;  r_data = DATA_WIDTH'(r_txc);    end
      OFF_RX_STAT: begin r_ok = 1'b1;  r_data = DATA_WIDTH'(r_rxc);    end
      OFF_RX_DATA: begin r_ok = r_rxv; r_pop = r_rxv; r_data = DATA_WIDTH'(r_rxd); end
      OFF_RX_PEEK: begin r_ok = r_rxv; r_data = DATA_WIDTH'(r_rxd);    end
      OFF_INT:     begin r_ok = 1'b1;  r_data = DATA_WIDTH'(r_int);    end
      default:     r_ok = 1'b0;
    endcase
    if (!(mem_re_i && r_ch_ok)) begin
      r_ok  = 1'b0;
      r_pop = 1'b0;
    end
    if (!r_ok) r_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rx_ready_o[c] = r_pop && (r_ch == CH_BITS'(c)) && !srst_i;
    end
  end

  // Registered read response, one cycle after mem_re_i
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      mem_rvalid_o <= 1'b0;
      mem_rdata_o  <= '0;
      mem_rresp_o  <= RESP_OKAY;
    end else begin
      mem_rvalid_o <= mem_re_i;
      if (mem_re_i) begin
        mem_rdata_o <= r_data;
        mem_rresp_o <= r_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Output packing
  assign ctrl_clk_en_o = clk_en_q;
  assign tx_flush_o    = tx_flush_q;
  assign rx_flush_o    = rx_flush_q;
  assign irq_o         = irq_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_out
    assign cfg_o[9*c +: 9]                      = cfg_q[c];
    assign clk_div_o[DATA_WIDTH*c +: DATA_WIDTH] = div_q[c];
  end

endmodule

// File: tb/tb_uart_mc_regif.sv
// Bench for uart_mc_regif: directed walk through the register map followed by
// randomized traffic, checked against a behavioural model of the register file.
// Three channels are instantiated so that a 2-bit channel field can address an
// unimplemented channel (ch=3).
module tb_uart_mc_regif;
  localparam int NCH = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic srst;

  // ---------------- DUT signals ----------------
  logic             we, re;
  logic [7:0]       waddr, raddr;
  logic [31:0]      wdata;
  logic [3:0]       wstrb;
  logic [1:0]       wresp, rresp;
  logic             rvalid;
  logic [31:0]      rdata;
  logic [NCH-1:0]   clk_en_o, txf_o, rxf_o, tx_valid_o, rx_ready_o, irq_o;
  logic [NCH-1:0]   tx_ready, rx_valid;
  logic [NCH*9-1:0] cfg_o;
  logic [NCH*32-1:0] div_o;
  logic [NCH*8-1:0] tx_cnt, rx_cnt, rx_data;
  logic [7:0]       tx_data_o;
  logic [NCH*6-1:0] evt;

  uart_mc_regif #(.NUM_CH(NCH)) dut (
    .clk_i(clk), .srst_i(srst),
    .mem_we_i(we), .mem_waddr_i(waddr), .mem_wdata_i(wdata), .mem_wstrb_i(wstrb),
    .mem_wresp_o(wresp),
    .mem_re_i(re), .mem_raddr_i(raddr),
    .mem_rvalid_o(rvalid), .mem_rdata_o(rdata), .mem_rresp_o(rresp),
    .ctrl_clk_en_o(clk_en_o), .tx_flush_o(txf_o), .rx_flush_o(rxf_o),
    .cfg_o(cfg_o), .clk_div_o(div_o),
    .tx_count_i(tx_cnt), .rx_count_i(rx_cnt),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready_o),
    .evt_i(evt), .irq_o(irq_o)
  );

  // ---------------- reference model ----------------
  logic [NCH-1:0] m_clk_en, m_txf, m_rxf;
  logic [8:0]     m_cfg [NCH];
  logic [31:0]    m_div [NCH];
  logic [5:0]     m_int [NCH];
  logic           exp_rv;
  bit             mon_en = 1'b0;

  logic [33:0] exp_q[$];   // {rresp, rdata}
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic bit exp_wr_ok(input logic [7:0] a, input logic [3:0] s);
    int ch;
    ch = int'(a[7:6]);
    if (ch >= NCH) return 1'b0;
    case (a[5:0])
      6'h00, 6'h20: return 1'b1;
      6'h04, 6'h08: return (tx_cnt[ch*8 +: 8] == 8'h0) && (rx_cnt[ch*8 +: 8] == 8'h0);
      6'h14:        return s[0] && tx_ready[ch];
      default:      return 1'b0;
    endcase
  endfunction

  function automatic logic [33:0] exp_rd(input logic [7:0] a);
    int ch;
    logic [33:0] err;
    ch  = int'(a[7:6]);
    err = {2'b10, 32'h0};
    if (ch >= NCH) return err;
    case (a[5:0])
      6'h00: return {2'b00, 31'h0, m_clk_en[ch]};
      6'h04: return {2'b00, 23'h0, m_cfg[ch]};
      6'h08: return {2'b00, m_div[ch]};
      6'h0C: return {2'b00, 24'h0, tx_cnt[ch*8 +: 8]};
      6'h10: return {2'b00, 24'h0, rx_cnt[ch*8 +: 8]};
      6'h18, 6'h1C: return rx_valid[ch] ? {2'b00, 24'h0, rx_data[ch*8 +: 8]} : err;
      6'h20: return {2'b00, 26'h0, m_int[ch]};
      default: return err;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called just after a falling edge with inputs set; checks the combinational
  // outputs, queues any read expectation, then advances the model over one edge.
  task automatic step();
    int          wch, rch;
    bit          wok;
    logic [33:0] er;
    logic [NCH-1:0] etv, err;
    logic [31:0] tmp;
    logic [5:0]  clr;
    #1;
    wch = int'(waddr[7:6]);
    rch = int'(raddr[7:6]);
    wok = exp_wr_ok(waddr, wstrb);
    er  = exp_rd(raddr);
    etv = '0;
    err = '0;
    if (!srst && we && wok && waddr[5:0] == 6'h14) etv[wch] = 1'b1;
    if (!srst && re && er[33:32] == 2'b00 && raddr[5:0] == 6'h18) err[rch] = 1'b1;
    chk("tx_valid", 64'(tx_valid_o), 64'(etv));
    chk("rx_ready", 64'(rx_ready_o), 64'(err));
    if (!srst && we) begin
      chk("wresp", 64'(wresp), wok ? 64'h0 : 64'h2);
      chk("tx_data", 64'(tx_data_o), 64'(wdata[7:0]));
    end
    if (!srst && re) exp_q.push_back(er);
    @(posedge clk);
    if (srst) begin
      m_clk_en = '0;
      m_txf    = '0;
      m_rxf    = '0;
      for (int c = 0; c < NCH; c++) begin
        m_cfg[c] = '0;
        m_div[c] = 32'h28B1;
        m_int[c] = '0;
      end
      mon_en = 1'b1;
    end else begin
      m_txf = '0;
      m_rxf = '0;
      clr   = '0;
      if (we && wok) begin
        case (waddr[5:0])
          6'h00: if (wstrb[0]) begin
            m_clk_en[wch] = wdata[0];
            m_txf[wch]    = wdata[1];
            m_rxf[wch]    = wdata[2];
          end
          6'h04: begin
            tmp = merge({23'h0, m_cfg[wch]}, wdata, wstrb);
            m_cfg[wch] = tmp[8:0];
          end
          6'h08: m_div[wch] = merge(m_div[wch], wdata, wstrb);
          6'h20: if (wstrb[0]) clr = wdata[5:0];
          default: ;
        endcase
      end
      for (int c = 0; c < NCH; c++)
        m_int[c] = (m_int[c] & ~((c == wch) ? clr : 6'h0)) | evt[c*6 +: 6];
    end
    exp_rv = re && !srst;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int ch, input logic [5:0] off, input logic [31:0] d,
                    input logic [3:0] s);
    we = 1'b1; waddr = {2'(ch), off}; wdata = d; wstrb = s;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input int ch, input logic [5:0] off);
    re = 1'b1; raddr = {2'(ch), off};
    step();
    re = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [33:0]    e;
    logic [NCH-1:0] eirq;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        chk("rvalid", 64'(rvalid), 64'(exp_rv));
        if (rvalid) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: got rvalid with rdata %0h, required no response", rdata);
          end else begin
            e = exp_q.pop_front();
            chk("rresp", 64'(rresp), 64'(e[33:32]));
            chk("rdata", 64'(rdata), 64'(e[31:0]));
          end
        end
        chk("clk_en", 64'(clk_en_o), 64'(m_clk_en));
        chk("tx_flush", 64'(txf_o), 64'(m_txf));
        chk("rx_flush", 64'(rxf_o), 64'(m_rxf));
        for (int c = 0; c < NCH; c++) begin
          eirq[c] = |(m_int[c] & m_cfg[c][8:3]);
          chk("cfg_o", 64'(cfg_o[c*9 +: 9]), 64'(m_cfg[c]));
          chk("clk_div_o", 64'(div_o[c*32 +: 32]), 64'(m_div[c]));
        end
        chk("irq", 64'(irq_o), 64'(eirq));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0] offs [10];

  initial begin
    offs = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h20, 6'h24};
    srst = 1'b1; we = 1'b0; re = 1'b0; waddr = '0; raddr = '0; wdata = '0; wstrb = '0;
    tx_ready = '0; rx_valid = '0; rx_data = '0; tx_cnt = '0; rx_cnt = '0; evt = '0;
    exp_rv = 1'b0;
    idle(2);
    srst = 1'b0;

    // reset values
    rd(1, 6'h08);
    rd(0, 6'h20);
    rd(2, 6'h04);

    // strobed CLK_DIV, busy-channel rejection
    wr(0, 6'h08, 32'hAABBCCDD, 4'b0101);
    rd(0, 6'h08);
    tx_cnt[7:0] = 8'd3;
    wr(0, 6'h08, 32'hFFFFFFFF, 4'hF);
    rd(0, 6'h08);
    wr(1, 6'h08, 32'h12345678, 4'hF);
    rd(1, 6'h08);
    tx_cnt = '0;
    rx_cnt[7:0] = 8'd1;
    wr(0, 6'h04, 32'h1FF, 4'h3);
    rd(0, 6'h10);
    rx_cnt = '0;

    // flush pulses, strobe-less write
    wr(1, 6'h00, 32'h6, 4'h1);
    idle(1);
    rd(1, 6'h00);
    wr(0, 6'h00, 32'h1, 4'h0);
    wr(0, 6'h00, 32'h1, 4'h1);

    // TX push
    tx_ready = '1;
    wr(0, 6'h14, 32'h1A5, 4'h1);
    tx_ready = '0;
    wr(0, 6'h14, 32'hA5, 4'h1);
    tx_ready = '1;
    wr(0, 6'h14, 32'h5A, 4'h0);

    // RX peek / pop
    rx_valid = 3'b010;
    rx_data[15:8] = 8'h3C;
    rd(1, 6'h1C);
    rd(1, 6'h18);
    rx_valid = '0;
    rd(1, 6'h18);
    rd(1, 6'h1C);

    // interrupt status and irq
    wr(0, 6'h04, 32'h10, 4'h1);
    evt[1] = 1'b1;
    idle(1);
    evt = '0;
    rd(0, 6'h20);
    evt[1] = 1'b1;
    wr(0, 6'h20, 32'h2, 4'h1);
    evt = '0;
    rd(0, 6'h20);
    wr(0, 6'h20, 32'h2, 4'h1);
    idle(1);
    rd(0, 6'h20);

    // unimplemented channel / offsets / read-only
    wr(3, 6'h08, 32'h1, 4'hF);
    rd(3, 6'h08);
    wr(0, 6'h24, 32'h1, 4'hF);
    rd(0, 6'h24);
    rd(0, 6'h02);
    wr(2, 6'h0C, 32'h1, 4'hF);
    rd(2, 6'h14);

    // simultaneous read and write of CTRL returns the old value
    we = 1'b1; waddr = {2'd0, 6'h00}; wdata = 32'h0; wstrb = 4'h1;
    re = 1'b1; raddr = {2'd0, 6'h00};
    step();
    we = 1'b0; re = 1'b0;
    rd(0, 6'h00);

    // back-to-back reads
    re = 1'b1;
    for (int i = 0; i < 10; i++) begin
      raddr = {2'(i % NCH), offs[i]};
      step();
    end
    re = 1'b0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      we       = ($urandom_range(0, 1) == 1);
      re       = ($urandom_range(0, 1) == 1);
      waddr    = {2'($urandom_range(0, 3)), offs[$urandom_range(0, 9)]};
      raddr    = {2'($urandom_range(0, 3)), offs[$urandom_range(0, 9)]};
      if ($urandom_range(0, 9) == 0) waddr[5:0] = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) raddr[5:0] = 6'($urandom_range(0, 63));
      wdata    = $urandom();
      wstrb    = 4'($urandom_range(0, 15));
      tx_ready = NCH'($urandom_range(0, 7));
      rx_valid = NCH'($urandom_range(0, 7));
      rx_data  = (NCH*8)'($urandom());
      evt      = (NCH*6)'($urandom() & $urandom() & $urandom());
      for (int c = 0; c < NCH; c++) begin
        tx_cnt[c*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h0;
        rx_cnt[c*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h0;
      end
      srst = (i == 300);
      step();
    end
    srst = 1'b0; we = 1'b0; re = 1'b0; evt = '0;
    idle(3);
    chk("queue_drain", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
